// File: rtl/cakegame_play_detector_pkg.sv
// Shared definitions for the cake-game play detector: default sizing and
// the detector FSM state encoding exposed on det_state.
package cakegame_play_detector_pkg;

  localparam int unsigned DEFAULT_NUM_BUTTONS     = 4;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam int unsigned STATE_W                 = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    DB_PRESS = 3'd1,
    EMIT     = 3'd2,
    WAIT_REL = 3'd3,
    DB_REL   = 3'd4
  } det_state_e;

endpackage

// File: rtl/cakegame_play_detector_if.sv
// Play-detector bus: control-unit enable and raw buttons in, debounced
// play events and debug state out. master = control side, slave = detector.
interface cakegame_play_detector_if #(
  parameter int unsigned NUM_BUTTONS = 4,
  parameter int unsigned CODE_W      = 2
);
  import cakegame_play_detector_pkg::*;

  logic                   enable;
  logic [NUM_BUTTONS-1:0] buttons;
  logic                   has_play;
  logic [CODE_W-1:0]      play;
  logic                   invalid_play;
  logic [STATE_W-1:0]     det_state;

  modport master (
    output enable, buttons,
    input  has_play, play, invalid_play, det_state
  );

  modport slave (
    input  enable, buttons,
    output has_play, play, invalid_play, det_state
  );

endinterface

// File: rtl/cakegame_play_detector_sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous bits.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage resynchronisation into the clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cakegame_play_detector.sv
// Turns raw cake buttons into debounced one-shot play events: one has_play
// (with the button index on play) or one invalid_play per press/release cycle.
module cakegame_play_detector
  import cakegame_play_detector_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = DEFAULT_NUM_BUTTONS,
  parameter int unsigned CODE_W          = $clog2(NUM_BUTTONS),
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input logic                     clock,
  input logic                     reset,
  cakegame_play_detector_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BUTTONS-1:0] sync;
  logic [NUM_BUTTONS-1:0] snap;
  logic                   any;
  logic                   any_d;
  logic [1:0]             fill;
  logic                   armed;
  logic [CNT_W-1:0]       cnt;
  det_state_e             state;
  det_state_e             state_next;
  logic                   cnt_clr;
  logic                   cnt_inc;
  logic                   snap_load;
  logic                   emit_entry;
  logic                   snap_one_hot;
  logic [CODE_W-1:0]      snap_index;
  logic                   has_play_q;
  logic                   invalid_q;
  logic [CODE_W-1:0]      play_q;

  sync_2ff #(.WIDTH(NUM_BUTTONS)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.buttons),
    .q     (sync)
  );

  assign any          = |sync;
  assign snap_one_hot = (snap != '0) && ((snap & (snap - NUM_BUTTONS'(1))) == '0);
  assign emit_entry   = (state_next == EMIT);

  // Binary index of the captured button (meaningful only when one-hot).
  always_comb begin
    snap_index = '0;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      if (snap[i]) snap_index = CODE_W'(i);
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    snap_load  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable && any && !any_d && armed) begin
          state_next = DB_PRESS;
          snap_load  = 1'b1;
          cnt_clr    = 1'b1;
        end
      end
      DB_PRESS: begin
        if (!bus.enable || (sync != snap)) state_next = IDLE;
        else if (cnt == CNT_LAST)          state_next = EMIT;
        else                               cnt_inc    = 1'b1;
      end
      EMIT: state_next = WAIT_REL;
      WAIT_REL: begin
        if (!any) begin
          state_next = DB_REL;
          cnt_clr    = 1'b1;
        end
      end
      DB_REL: begin
        if (any)                   state_next = WAIT_REL;
        else if (cnt == CNT_LAST)  state_next = IDLE;
        else                       cnt_inc    = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Debounce counter, press snapshot and release history.
  // armed: the synchronizer reads all-zero while it refills after reset, so a
  // button held through reset would look like a fresh press; a press edge is
  // only trusted once a genuine all-released level has been seen.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      snap  <= '0;
      any_d <= 1'b0;
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      any_d <= any;
      fill  <= {fill[0], 1'b1};
      armed <= armed | (fill[1] & ~any);
      if (snap_load) snap <= sync;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
    end
  end

  // Registered event outputs, valid for the single EMIT cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      has_play_q <= 1'b0;
      invalid_q  <= 1'b0;
      play_q     <= '0;
    end else begin
      has_play_q <= emit_entry && snap_one_hot;
      invalid_q  <= emit_entry && !snap_one_hot;
      if (emit_entry && snap_one_hot) play_q <= snap_index;
    end
  end

  assign bus.has_play     = has_play_q;
  assign bus.invalid_play = invalid_q;
  assign bus.play         = play_q;
  assign bus.det_state    = state;

endmodule
